ready_valid_rr_arbiter: RTL and testbench

//   Shares one ready/valid output stream among N ready/valid requesters, with DATA_W-bit payloads.

---
 rtl/ready_valid_pkg.sv | 30 +++
 rtl/ready_valid_rr_arbiter_pick.sv | 42 ++++
 rtl/ready_valid_rr_arbiter.sv | 110 +++++++++++
 tb/tb_ready_valid_rr_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ready_valid_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : ready_valid_pkg
//  Brief   : Shared constants and width helpers for the ready/valid arbiter
//  Revision: 1.0  initial release
// ============================================================================
package ready_valid_pkg;

  localparam int N_DEF      = 4;
  localparam int DATA_W_DEF = 5;

  // Ceiling log2; clog2(1) = 0. Bounded loop keeps it usable in constant context.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Index width for an N-way selector; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : clog2(n);
  endfunction

  localparam int IDX_W = idx_width(N_DEF);

endpackage
`default_nettype wire

// File: rtl/ready_valid_rr_arbiter_pick.sv
`default_nettype none
// ============================================================================
//  Module  : rr_pick
//  Brief   : Combinational round-robin selector. Keeps the previous winner
//            when hold is set, otherwise scans last+1, last+2, ... mod N.
//  Revision: 1.0  initial release
// ============================================================================
module rr_pick
  import ready_valid_pkg::*;
#(
  parameter  int N     = N_DEF,
  localparam int SEL_W = idx_width(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [SEL_W-1:0] last_i,
  input  logic             hold_i,
  output logic [SEL_W-1:0] grant_o,
  output logic             none_o
);

  // Rotated priority scan starting just after the previous winner
  always_comb begin
    logic found;
    int   idx;
    grant_o = last_i;
    none_o  = ~|req_i;
    found   = hold_i;
    idx     = 0;
    for (int k = 1; k <= N; k++) begin
      // last_i < 2N and k <= N, so two conditional subtracts give the mod-N wrap
      idx = int'(last_i) + k;
      if (idx >= N) idx = idx - N;
      if (idx >= N) idx = idx - N;
      if (!found && req_i[idx]) begin
        grant_o = SEL_W'(idx);
        found   = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ready_valid_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : ready_valid_rr_arbiter
//  Brief   : N-way ready/valid round-robin arbiter with bounded bursts and a
//            one-entry registered output stage (latency 1, full throughput).
//  Revision: 1.0  initial release
// ============================================================================
module ready_valid_rr_arbiter
  import ready_valid_pkg::*;
#(
  parameter  int N         = N_DEF,
  parameter  int DATA_W    = DATA_W_DEF,
  parameter  int MAX_BURST = 2,
  localparam int SEL_W     = idx_width(N)
) (
  input  logic                CLK,
  input  logic                ASYNCRESETN,
  input  logic [N*DATA_W-1:0] I_data,
  input  logic [N-1:0]        I_valid,
  output logic [N-1:0]        I_ready,
  output logic [DATA_W-1:0]   O_data,
  output logic                O_valid,
  input  logic                O_ready,
  output logic [SEL_W-1:0]    O_src
);

  localparam int BURST_W = clog2(MAX_BURST + 1);

  logic [SEL_W-1:0]   last_q,  last_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [DATA_W-1:0]  data_q,  data_d;
  logic [SEL_W-1:0]   src_q,   src_d;
  logic               valid_q, valid_d;

  logic               space;
  logic               hold;
  logic               none;
  logic               accept;
  logic [SEL_W-1:0]   grant;
  logic [DATA_W-1:0]  grant_data;

  // The output slot is free if empty or if its beat leaves this cycle
  assign space = !valid_q || O_ready;
  // Stay on the previous winner mid-burst while it keeps requesting
  assign hold  = I_valid[last_q] && (burst_q != '0) && (burst_q < BURST_W'(MAX_BURST));

  rr_pick #(
    .N (N)
  ) u_pick (
    .req_i   (I_valid),
    .last_i  (last_q),
    .hold_i  (hold),
    .grant_o (grant),
    .none_o  (none)
  );

  // One-hot ready decode, forced low while reset is asserted
  always_comb begin
    I_ready = '0;
    for (int i = 0; i < N; i++) begin
      I_ready[i] = ASYNCRESETN && space && !none && (grant == SEL_W'(i));
    end
  end

  assign accept     = |(I_valid & I_ready);
  assign grant_data = I_data[int'(grant)*DATA_W +: DATA_W];

  // Next-state: load on accept, drain on sink ready, end a burst on an idle slot
  always_comb begin
    last_d  = last_q;
    burst_d = burst_q;
    data_d  = data_q;
    src_d   = src_q;
    valid_d = valid_q;
    if (accept) begin
      data_d  = grant_data;
      src_d   = grant;
      valid_d = 1'b1;
      last_d  = grant;
      // A wrapped lone requester is not a hold, so its count restarts at 1
      burst_d = hold ? burst_q + BURST_W'(1) : BURST_W'(1);
    end else begin
      if (O_ready) valid_d = 1'b0;
      if (space)   burst_d = '0;
    end
  end

  // State registers with immediate reset; the in-flight beat is discarded
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      last_q  <= SEL_W'(N - 1);
      burst_q <= '0;
      data_q  <= '0;
      src_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      last_q  <= last_d;
      burst_q <= burst_d;
      data_q  <= data_d;
      src_q   <= src_d;
      valid_q <= valid_d;
    end
  end

  assign O_data  = data_q;
  assign O_src   = src_q;
  assign O_valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_ready_valid_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_ready_valid_rr_arbiter
//  Brief   : Scoreboard bench for ready_valid_rr_arbiter (N=4, DATA_W=5,
//            MAX_BURST=2)
//  Revision: 1.0  initial release
// ============================================================================
module tb_ready_valid_rr_arbiter;

  localparam int N         = 4;
  localparam int DATA_W    = 5;
  localparam int MAX_BURST = 2;

  logic                CLK;
  logic                ASYNCRESETN;
  logic [N*DATA_W-1:0] I_data;
  logic [N-1:0]        I_valid;
  logic [N-1:0]        I_ready;
  logic [DATA_W-1:0]   O_data;
  logic                O_valid;
  logic                O_ready;
  logic [1:0]          O_src;

  ready_valid_rr_arbiter #(
    .N         (N),
    .DATA_W    (DATA_W),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .CLK         (CLK),
    .ASYNCRESETN (ASYNCRESETN),
    .I_data      (I_data),
    .I_valid     (I_valid),
    .I_ready     (I_ready),
    .O_data      (O_data),
    .O_valid     (O_valid),
    .O_ready     (O_ready),
    .O_src       (O_src)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: expected beats {src,data}, last winner, burst count
  logic [6:0] sbq[$];
  int m_last  = N - 1;
  int m_burst = 0;

  // Hand-derived expectations for the current cycle; -1 disables
  int exp_src = -1;
  int exp_dat = -1;
  int exp_gnt = -1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called just after a falling edge with inputs set; checks, updates the model,
  // then advances to the next falling edge.
  task automatic cycle();
    bit         mv, sp, none_m, hold_m, found;
    int         g, idx;
    logic [3:0] exp_rdy;
    #1;
    mv = (sbq.size() != 0);
    check_eq("O_valid", {31'd0, O_valid}, {31'd0, mv});
    if (mv) begin
      check_eq("O_data", {27'd0, O_data}, {27'd0, sbq[0][4:0]});
      check_eq("O_src",  {30'd0, O_src},  {30'd0, sbq[0][6:5]});
    end
    if (exp_src >= 0) check_eq("order_src", {30'd0, O_src}, exp_src);
    if (exp_dat >= 0) check_eq("fixed_data", {27'd0, O_data}, exp_dat);

    sp     = !mv || O_ready;
    none_m = (I_valid == 4'b0000);
    hold_m = I_valid[m_last] && (m_burst != 0) && (m_burst < MAX_BURST);
    g      = m_last;
    found  = hold_m;
    for (int k = 1; k <= N; k++) begin
      idx = (m_last + k) % N;
      if (!found && I_valid[idx]) begin
        g     = idx;
        found = 1'b1;
      end
    end
    exp_rdy = (sp && !none_m) ? (4'b0001 << g) : 4'b0000;
    check_eq("I_ready", {28'd0, I_ready}, {28'd0, exp_rdy});
    if (exp_gnt >= 0) check_eq("fixed_grant", {28'd0, I_ready}, 32'd1 << exp_gnt);

    if (mv && O_ready) void'(sbq.pop_front());
    if (sp && !none_m) begin
      sbq.push_back({2'(g), I_data[g*DATA_W +: DATA_W]});
      m_burst = hold_m ? m_burst + 1 : 1;
      m_last  = g;
    end else if (sp) begin
      m_burst = 0;
    end
    @(negedge CLK);
  endtask

  // All four streams valid, stream i carrying i+1; grant order checked one cycle later
  task automatic run_full_rotation();
    int order[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    I_valid = 4'b1111;
    I_data  = {5'd4, 5'd3, 5'd2, 5'd1};
    O_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      exp_src = (c == 0) ? -1 : order[c-1];
      cycle();
    end
    exp_src = -1;
  endtask

  // Watchdog: the bench is cycle-stepped, so this only fires on a simulator stall
  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1);
  end

  initial begin
    ASYNCRESETN = 1'b0;
    I_valid     = 4'b1111;
    I_data      = '0;
    O_ready     = 1'b1;
    #1;
    // Reset state, ready gated off despite valid requests
    check_eq("rst_I_ready", {28'd0, I_ready}, 32'd0);
    check_eq("rst_O_valid", {31'd0, O_valid}, 32'd0);
    check_eq("rst_O_data",  {27'd0, O_data},  32'd0);
    check_eq("rst_O_src",   {30'd0, O_src},   32'd0);
    @(negedge CLK);
    @(negedge CLK);
    ASYNCRESETN = 1'b1;
    I_valid     = 4'b0000;

    // Idle: nothing requested for 20 cycles
    for (int c = 0; c < 20; c++) cycle();

    // Full rotation with MAX_BURST=2
    run_full_rotation();

    // Lone requester: stream 2 streams 01..05 without a bubble
    for (int c = 0; c < 6; c++) begin
      I_valid = (c < 5) ? 4'b0100 : 4'b0000;
      I_data  = '0;
      I_data[14:10] = 5'(c + 1);
      exp_src = (c == 0) ? -1 : 2;
      exp_dat = (c == 0) ? -1 : c;
      cycle();
    end
    exp_src = -1;
    exp_dat = -1;

    // Backpressure: 0A held for 3 stalled cycles, 0B loads on the release edge
    I_valid = 4'b0001;
    I_data  = {15'd0, 5'h0A};
    O_ready = 1'b1;
    cycle();
    I_data  = {15'd0, 5'h0B};
    O_ready = 1'b0;
    exp_dat = 5'h0A;
    for (int c = 0; c < 3; c++) cycle();
    O_ready = 1'b1;
    cycle();
    I_valid = 4'b0000;
    exp_dat = 5'h0B;
    cycle();
    exp_dat = -1;
    cycle();

    // Stream 1 drops after one beat: stream 3 takes over and finishes its burst first
    I_data  = {5'h13, 5'h00, 5'h11, 5'h00};
    I_valid = 4'b1010; exp_gnt = 1; exp_src = -1; cycle();
    I_valid = 4'b1000; exp_gnt = 3; exp_src = 1;  cycle();
    I_valid = 4'b1010; exp_gnt = 3; exp_src = 3;  cycle();
    I_valid = 4'b1010; exp_gnt = 1; exp_src = 3;  cycle();
    I_valid = 4'b0000; exp_gnt = -1; exp_src = 1; cycle();
    exp_src = -1;
    cycle();

    // Asynchronous reset between edges while a beat is in flight
    I_valid = 4'b1111;
    I_data  = {5'd4, 5'd3, 5'd2, 5'd1};
    O_ready = 1'b1;
    cycle();
    cycle();
    #2;
    ASYNCRESETN = 1'b0;
    #1;
    check_eq("arst_O_valid", {31'd0, O_valid}, 32'd0);
    check_eq("arst_I_ready", {28'd0, I_ready}, 32'd0);
    check_eq("arst_O_src",   {30'd0, O_src},   32'd0);
    sbq.delete();
    m_last  = N - 1;
    m_burst = 0;
    @(negedge CLK);
    @(negedge CLK);
    ASYNCRESETN = 1'b1;
    run_full_rotation();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
